// File: rtl/shift_reg_piso_tx.sv
// shift_reg_piso_tx: parallel-in / serial-out transmitter.
// Takes a WIDTH-bit word through a valid/ready handshake and shifts it out
// one bit per clock. frame_start marks bit 0 of each word.
//
// Handshake: a word is taken on a falling clk edge when load_valid and
// load_ready are both high. load_ready is a combinational function of state
// only, so the producer may hold load_valid high and wait. parallel_data_in is
// sampled only on that accepted edge.
//
// All state changes on the falling edge of clk. The receiver samples on the
// rising edge, which falls in the middle of each bit.
module shift_reg_piso_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] parallel_data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;

   // State register. Reset is asynchronous, so an aborted word is dropped at once.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state: load, shift, reload on the last bit for gapless streaming,
   // or return to idle.
   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (load_valid) begin
               shreg_nxt = parallel_data_in;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt != LAST) begin
               // Mid-frame: shift toward the output end and ignore load_valid.
               if (MSB_FIRST) begin
                  shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
               end else begin
                  shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
               end
               cnt_nxt = cnt + 1'b1;
            end else if (load_valid) begin
               // The next word follows the last bit without an idle cycle.
               shreg_nxt = parallel_data_in;
               cnt_nxt   = '0;
            end else begin
               state_nxt = IDLE;
               shreg_nxt = '0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            shreg_nxt = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs decoded from the registered state. serial_out is held at 0 while idle.
   always_comb begin
      busy         = (state == SHIFT);
      serial_valid = (state == SHIFT);
      frame_start  = (state == SHIFT) && (cnt == '0);
      load_ready   = (state == IDLE) || (cnt == LAST);
      serial_out   = 1'b0;
      if (state == SHIFT) begin
         serial_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      end
   end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Bench for shift_reg_piso_tx: one MSB-first and one LSB-first instance.
// Expected {frame_start, bit} pairs are queued when a word is driven and are
// popped at every rising edge on which serial_valid is high.
module tb_shift_reg_piso_tx;

   localparam int W = 4;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] data_m = '0;
   logic [W-1:0] data_l = '0;
   logic         lv_m = 1'b0;
   logic         lv_l = 1'b0;
   logic         rdy_m, so_m, sv_m, fs_m, busy_m;
   logic         rdy_l, so_l, sv_l, fs_l, busy_l;

   logic [1:0]   exp_m[$];
   logic [1:0]   exp_l[$];
   int           total = 0;
   int           bad   = 0;

   always #5 clk = ~clk;

   shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk              (clk),
      .reset            (reset),
      .parallel_data_in (data_m),
      .load_valid       (lv_m),
      .load_ready       (rdy_m),
      .serial_out       (so_m),
      .serial_valid     (sv_m),
      .frame_start      (fs_m),
      .busy             (busy_m)
   );

   shift_reg_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk              (clk),
      .reset            (reset),
      .parallel_data_in (data_l),
      .load_valid       (lv_l),
      .load_ready       (rdy_l),
      .serial_out       (so_l),
      .serial_valid     (sv_l),
      .frame_start      (fs_l),
      .busy             (busy_l)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected serial stream of a word, independent of any shifting detail.
   task automatic push_m(input logic [W-1:0] d);
      for (int i = W - 1; i >= 0; i--) exp_m.push_back({(i == W - 1), d[i]});
   endtask

   task automatic push_l(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) exp_l.push_back({(i == 0), d[i]});
   endtask

   // Advance to just after the next rising edge (mid-bit) and check both instances.
   task automatic step();
      logic [1:0] e;
      @(posedge clk);
      #1;
      if (sv_m) begin
         chk("m_busy", busy_m, 1);
         if (exp_m.size() == 0) begin
            chk("m_extra_bit", sv_m, 0);
         end else begin
            e = exp_m.pop_front();
            chk("m_bit", so_m, e[0]);
            chk("m_fs", fs_m, e[1]);
         end
      end else begin
         chk("m_idle_so", so_m, 0);
         chk("m_idle_fs", fs_m, 0);
         chk("m_idle_busy", busy_m, 0);
         chk("m_idle_rdy", rdy_m, 1);
      end
      if (sv_l) begin
         chk("l_busy", busy_l, 1);
         if (exp_l.size() == 0) begin
            chk("l_extra_bit", sv_l, 0);
         end else begin
            e = exp_l.pop_front();
            chk("l_bit", so_l, e[0]);
            chk("l_fs", fs_l, e[1]);
         end
      end else begin
         chk("l_idle_so", so_l, 0);
         chk("l_idle_fs", fs_l, 0);
         chk("l_idle_busy", busy_l, 0);
         chk("l_idle_rdy", rdy_l, 1);
      end
   endtask

   initial begin
      // Power-up reset
      step();
      step();
      reset = 1'b1;
      step();

      // Reset asserted mid-cycle while load_valid is high: outputs idle, no frame
      data_m = 4'b1011;
      lv_m   = 1'b1;
      reset  = 1'b0;
      #1;
      chk("rst_rdy", rdy_m, 1);
      chk("rst_sv", sv_m, 0);
      chk("rst_so", so_m, 0);
      chk("rst_fs", fs_m, 0);
      chk("rst_busy", busy_m, 0);
      step();
      chk("rst_no_frame", sv_m, 0);
      lv_m  = 1'b0;
      reset = 1'b1;
      step();

      // Single word, MSB first: 1,0,1,1
      data_m = 4'b1011;
      lv_m   = 1'b1;
      push_m(data_m);
      step();
      chk("single_latency", sv_m, 1);
      lv_m   = 1'b0;
      data_m = '0;
      step();
      chk("single_rdy_b1", rdy_m, 0);
      step();
      step();
      chk("single_rdy_last", rdy_m, 1);
      step();
      chk("single_end", sv_m, 0);

      // Back-to-back: 1011 then 0110 offered on the last bit
      data_m = 4'b1011;
      lv_m   = 1'b1;
      push_m(4'b1011);
      push_m(4'b0110);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("b2b_busy", busy_m, 1);
         if (i == 0) data_m = 4'b0110;
         if (i == 1 || i == 2) chk("b2b_rdy_mid", rdy_m, 0);
         if (i == 3) chk("b2b_rdy_last", rdy_m, 1);
         if (i == 4) begin
            chk("b2b_fs2", fs_m, 1);
            lv_m = 1'b0;
         end
      end
      step();
      chk("b2b_end", sv_m, 0);

      // LSB first: 1011 -> 1,1,0,1
      data_l = 4'b1011;
      lv_l   = 1'b1;
      push_l(data_l);
      step();
      chk("lsb_latency", sv_l, 1);
      lv_l   = 1'b0;
      data_l = '0;
      step();
      step();
      step();
      step();
      chk("lsb_end", sv_l, 0);

      // Hold-off: new data offered mid-frame must not disturb the frame
      data_m = 4'b1011;
      lv_m   = 1'b1;
      push_m(data_m);
      step();
      data_m = 4'b1111;
      step();
      chk("hold_rdy_b1", rdy_m, 0);
      step();
      chk("hold_rdy_b2", rdy_m, 0);
      lv_m = 1'b0;
      step();
      chk("hold_rdy_b3", rdy_m, 1);
      step();
      chk("hold_end", sv_m, 0);

      // Reset after two bits, then a clean word with no residue
      data_m = 4'b1011;
      lv_m   = 1'b1;
      push_m(data_m);
      step();
      lv_m = 1'b0;
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_sv", sv_m, 0);
      chk("midrst_so", so_m, 0);
      chk("midrst_fs", fs_m, 0);
      chk("midrst_busy", busy_m, 0);
      chk("midrst_rdy", rdy_m, 1);
      exp_m.delete();
      step();
      reset = 1'b1;
      step();
      data_m = 4'b0001;
      lv_m   = 1'b1;
      push_m(data_m);
      step();
      chk("post_rst_latency", sv_m, 1);
      lv_m = 1'b0;
      step();
      step();
      step();
      step();
      chk("post_rst_end", sv_m, 0);

      // Anything still queued was never transmitted
      for (int i = 0; i < 10 && (exp_m.size() > 0 || exp_l.size() > 0); i++) step();
      chk("m_drain", exp_m.size(), 0);
      chk("l_drain", exp_l.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
